bcd_seg_scan: RTL

Multiplexed seven-segment driver for the BCD calculator datapath's result side. It snapshots the ALU's packed BCD result, the two BCD operands and the operation select, then time-multiplexes them onto an 8-digit common-anode display. New values are applied only at frame boundaries, so a digit set never tears mid-scan. It sits between the BCD ALU outputs and the board's anode and cathode pins.

---
 rtl/bcd_disp_pkg.sv | 49 ++++
 rtl/bcd_to_seg.sv | 33 +++
 rtl/bcd_seg_scan.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD seven-segment scan driver: active-low glyph
// patterns (seg[0]=a .. seg[6]=g), slot indices and the captured display record.
package bcd_disp_pkg;

  localparam int NUM_SLOTS = 5;

  typedef enum logic [2:0] {
    SLOT_RES_U = 3'd0,
    SLOT_RES_T = 3'd1,
    SLOT_OPA   = 3'd2,
    SLOT_OPB   = 3'd3,
    SLOT_OP    = 3'd4
  } slot_e;

  typedef struct packed {
    logic [7:0] result;
    logic [3:0] units;
    logic [3:0] tens;
    logic [1:0] ctrl;
  } disp_rec_t;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_S     = GLYPH_5;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  // Operation glyph: add shows 'A', subtract 'S', either clear code shows '-'.
  function automatic logic [6:0] op_glyph(input logic [1:0] ctrl);
    logic [6:0] g;
    case (ctrl)
      2'b00:   g = GLYPH_A;
      2'b01:   g = GLYPH_S;
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder with blanking.
// Nibbles above 9 render as 'E'.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Glyph lookup; blanking overrides the digit.
  always_comb begin
    seg_o = GLYPH_E;
    if (blank_i) begin
      seg_o = GLYPH_BLANK;
    end else begin
      case (nib_i)
        4'd0:    seg_o = GLYPH_0;
        4'd1:    seg_o = GLYPH_1;
        4'd2:    seg_o = GLYPH_2;
        4'd3:    seg_o = GLYPH_3;
        4'd4:    seg_o = GLYPH_4;
        4'd5:    seg_o = GLYPH_5;
        4'd6:    seg_o = GLYPH_6;
        4'd7:    seg_o = GLYPH_7;
        4'd8:    seg_o = GLYPH_8;
        4'd9:    seg_o = GLYPH_9;
        default: seg_o = GLYPH_E;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed 5-slot seven-segment driver for the BCD calculator result side.
// Loads land in a pending register and are promoted to the display register
// only at the slot 4->0 wrap, so a frame never shows a mix of old and new data.
// Build option: define BCD_LZB_EN to blank a zero tens digit of the result
// (slot 1) and a zero operand-B digit (slot 3); anodes keep scanning normally.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] result,
  input  logic [3:0] units_BCD,
  input  logic [3:0] tens_BCD,
  input  logic [1:0] ctrl,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(REFRESH_DIV - 1);
  localparam slot_e LAST_SLOT = slot_e'(NUM_SLOTS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  slot_e         idx_q, idx_d;
  disp_rec_t     in_rec;
  disp_rec_t     pend_q, pend_d;
  disp_rec_t     disp_q, disp_d;
  logic          pend_vld_q, pend_vld_d;
  logic          tc, wrap;
  logic          wrap_q;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          fd_q;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    dig_seg;

  assign in_rec = {result, units_BCD, tens_BCD, ctrl};

  // State register: scan position, load path and registered pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= SLOT_RES_U;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      wrap_q     <= 1'b0;
      an_q       <= 8'hFF;
      seg_q      <= GLYPH_BLANK;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      wrap_q     <= wrap;
      an_q       <= an_d;
      seg_q      <= seg_d;
      // Lines up with the cycle in which an_q returns to slot 0.
      fd_q       <= wrap_q;
    end
  end

  // Next-state: tick counter, slot advance, frame-boundary promotion of pending data.
  always_comb begin
    tc    = (cnt_q == CNT_TC);
    wrap  = tc && (idx_q == LAST_SLOT);
    cnt_d = tc ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tc) begin
      case (idx_q)
        SLOT_RES_U: idx_d = SLOT_RES_T;
        SLOT_RES_T: idx_d = SLOT_OPA;
        SLOT_OPA:   idx_d = SLOT_OPB;
        SLOT_OPB:   idx_d = SLOT_OP;
        default:    idx_d = SLOT_RES_U;
      endcase
    end
    pend_d     = load ? in_rec : pend_q;
    pend_vld_d = pend_vld_q | load;
    disp_d     = disp_q;
    if (wrap) begin
      // A load coinciding with the wrap is newer than anything pending.
      pend_vld_d = 1'b0;
      if (load) begin
        disp_d = in_rec;
      end else if (pend_vld_q) begin
        disp_d = pend_q;
      end
    end
  end

  // Output decode: anode select and nibble mux for the current slot.
  always_comb begin
    an_d = 8'hFF;
    nib  = disp_q.result[3:0];
    case (idx_q)
      SLOT_RES_U: begin an_d = 8'hFE; nib = disp_q.result[3:0]; end
      SLOT_RES_T: begin an_d = 8'hFD; nib = disp_q.result[7:4]; end
      SLOT_OPA:   begin an_d = 8'hFB; nib = disp_q.units;       end
      SLOT_OPB:   begin an_d = 8'hF7; nib = disp_q.tens;        end
      SLOT_OP:    begin an_d = 8'hEF; nib = 4'd0;               end
      default:    begin an_d = 8'hFF; nib = 4'd0;               end
    endcase
`ifdef BCD_LZB_EN
    blank = ((idx_q == SLOT_RES_T) && (disp_q.result[7:4] == 4'd0)) ||
            ((idx_q == SLOT_OPB)   && (disp_q.tens == 4'd0));
`else
    blank = 1'b0;
`endif
    seg_d = (idx_q == SLOT_OP) ? op_glyph(disp_q.ctrl) : dig_seg;
  end

  bcd_to_seg u_dec (
    .nib_i   (nib),
    .blank_i (blank),
    .seg_o   (dig_seg)
  );

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_done = fd_q;

endmodule
